// File: rtl/fetch_unit.sv
// fetch_unit: program counter and start/run/done sequencing for the 3BC fetch stage
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Ack,
  input  logic             BranchEn,
  input  logic             OffsetSrc,
  input  logic [PC_W-1:0]  LutOffset,
  input  logic [PC_W-1:0]  RegOffset,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [PC_W-1:0] sel_off;
  logic [CNT_W-1:0] cnt_next;
  // branch offset selection and saturating retire count
  always_comb begin
    sel_off  = OffsetSrc ? RegOffset : LutOffset;
    cnt_next = &InstrCount ? InstrCount : InstrCount + CNT_W'(1);
  end
  // reset > start > run sequencing; halt keeps PC on the halt word
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ProgCtr    <= '0;
      InstrCount <= '0;
      Running    <= 1'b0;
      Done       <= 1'b0;
    end else if (Start) begin
      state      <= RUN;
      ProgCtr    <= StartAddr;
      InstrCount <= '0;
      Running    <= 1'b1;
      Done       <= 1'b0;
    end else if (state == RUN) begin
      InstrCount <= cnt_next;
      if (Ack) begin
        state   <= DONE;
        Running <= 1'b0;
        Done    <= 1'b1;
      end else begin
        ProgCtr <= BranchEn ? ProgCtr + sel_off : ProgCtr + PC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit sequencing, branching, wrap and saturation
module tb_fetch_unit;
  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0, BranchEn = 1'b0, OffsetSrc = 1'b0;
  logic [9:0] StartAddr = '0, LutOffset = '0, RegOffset = '0;
  logic [9:0] pc, pc_s;
  logic run, done, run_s, done_s;
  logic [15:0] cnt;
  logic [3:0] cnt_s;
  int checks = 0, errors = 0;

  always #5 Clk = ~Clk;

  fetch_unit u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Ack(Ack),
    .BranchEn(BranchEn), .OffsetSrc(OffsetSrc), .LutOffset(LutOffset), .RegOffset(RegOffset),
    .ProgCtr(pc), .Running(run), .Done(done), .InstrCount(cnt)
  );

  fetch_unit #(.PC_W(10), .CNT_W(4)) u_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Ack(Ack),
    .BranchEn(BranchEn), .OffsetSrc(OffsetSrc), .LutOffset(LutOffset), .RegOffset(RegOffset),
    .ProgCtr(pc_s), .Running(run_s), .Done(done_s), .InstrCount(cnt_s)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_at(input logic [9:0] a);
    Start = 1'b1; StartAddr = a;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_pc", pc, 0); chk("rst_run", run, 0); chk("rst_done", done, 0); chk("rst_cnt", cnt, 0);
    Reset = 1'b0;
    tick();
    chk("idle_hold_pc", pc, 0); chk("idle_hold_run", run, 0);
    start_at(10'h000);
    chk("start_pc", pc, 0); chk("start_run", run, 1); chk("start_cnt", cnt, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("seq_pc", pc, i + 1);
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk("halt_done", done, 1); chk("halt_run", run, 0); chk("halt_pc", pc, 5); chk("halt_cnt", cnt, 6);
    chk("halt_cnt_sat", cnt_s, 6);
    BranchEn = 1'b1; LutOffset = 10'h010; Ack = 1'b1;
    tick();
    BranchEn = 1'b0; Ack = 1'b0;
    chk("done_hold_pc", pc, 5); chk("done_hold_cnt", cnt, 6); chk("done_hold_done", done, 1);
    start_at(10'h010);
    BranchEn = 1'b1; OffsetSrc = 1'b0; LutOffset = 10'h3F6; RegOffset = 10'h055;
    tick();
    chk("br_lut_neg", pc, 10'h006);
    OffsetSrc = 1'b1; RegOffset = 10'h004; LutOffset = 10'h123;
    tick();
    chk("br_reg", pc, 10'h00A); chk("br_cnt", cnt, 2);
    BranchEn = 1'b0;
    start_at(10'h3FF);
    tick();
    chk("pc_wrap", pc, 10'h000);
    start_at(10'h002);
    BranchEn = 1'b1; OffsetSrc = 1'b0; LutOffset = 10'h3FC;
    tick();
    chk("br_neg_wrap", pc, 10'h3FE);
    LutOffset = 10'h000;
    tick();
    chk("self_loop_pc", pc, 10'h3FE); chk("self_loop_cnt", cnt, 2);
    BranchEn = 1'b0;
    start_at(10'h020);
    Ack = 1'b1; BranchEn = 1'b1; LutOffset = 10'h008;
    tick();
    BranchEn = 1'b0;
    chk("ack_pri_done", done, 1); chk("ack_pri_pc", pc, 10'h020);
    Start = 1'b1; StartAddr = 10'h100;
    tick();
    Start = 1'b0; Ack = 1'b0;
    chk("start_ovr_run", run, 1); chk("start_ovr_done", done, 0);
    chk("start_ovr_pc", pc, 10'h100); chk("start_ovr_cnt", cnt, 0);
    start_at(10'h050);
    repeat (5) tick();
    chk("pre_abort_pc", pc, 10'h055);
    Reset = 1'b1;
    tick();
    chk("abort_pc", pc, 0); chk("abort_run", run, 0); chk("abort_done", done, 0); chk("abort_cnt", cnt, 0);
    Start = 1'b1; StartAddr = 10'h123;
    tick();
    chk("rst_wins_pc", pc, 0); chk("rst_wins_run", run, 0);
    Reset = 1'b0; Start = 1'b0;
    tick();
    chk("post_rst_idle_pc", pc, 0); chk("post_rst_idle_run", run, 0);
    start_at(10'h000);
    repeat (20) tick();
    chk("sat_cnt", cnt_s, 15); chk("wide_cnt", cnt, 20); chk("sat_pc", pc_s, 10'h014);
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    chk("sat_done", done_s, 1); chk("sat_done_cnt", cnt_s, 15);
    start_at(10'h200);
    chk("restart_cnt", cnt_s, 0); chk("restart_pc", pc_s, 10'h200); chk("restart_run", run_s, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter / fetch stage of the 3BC processor, directly upstream of the control decoder.
- Holds the PC that addresses instruction ROM; the ROM's 9-bit word feeds the decoder.
- Consumes the decoder's Ack ("done") and OffsetSrc outputs, plus the branch-taken decision.
- Sequences start / run / done for the testbench handshake and counts executed instructions.

Parameters:
- PC_W, default 10: program counter width; ROM depth 2**PC_W.
- CNT_W, default 16: width of executed-instruction counter.

Ports:
- Clk         input   1      system clock, all state updates on rising edge
- Reset       input   1      synchronous, active-high; sampled on rising edge of Clk
- Start       input   1      one-cycle pulse from testbench: begin program at StartAddr
- StartAddr   input   PC_W   program entry point, sampled only when Start=1
- Ack         input   1      from decoder: current instruction is 9'h1FF (halt)
- BranchEn    input   1      current instruction is a taken branch
- OffsetSrc   input   1      from decoder: 1 = use RegOffset, 0 = use LutOffset
- LutOffset   input   PC_W   signed two's-complement offset from branch LUT
- RegOffset   input   PC_W   signed two's-complement offset from register file
- ProgCtr     output  PC_W   current instruction address to instruction ROM
- Running     output  1      high while in RUN
- Done        output  1      high while in DONE (program finished)
- InstrCount  output  CNT_W  instructions retired since last Start

Behaviour:
- Reset (synchronous, active-high) has priority over all inputs. Next state: IDLE, ProgCtr=0, Running=0, Done=0, InstrCount=0. Reset mid-program aborts with no further PC update.
- States: IDLE, RUN, DONE. All outputs are registered. Running=(state==RUN); Done=(state==DONE).
- Start (any state, Reset=0): next edge ProgCtr<=StartAddr, InstrCount<=0, state<=RUN. Start overrides Ack and BranchEn in the same cycle. Start during RUN restarts the program.
- IDLE, no Start: hold all outputs.
- RUN, per cycle, one instruction per cycle (ROM read is combinational from ProgCtr):
  - If Ack=1: state<=DONE, ProgCtr held (points at halt word), InstrCount+=1 (halt counts as retired).
  - Else if BranchEn=1: ProgCtr<=ProgCtr+sel_off, where sel_off=OffsetSrc?RegOffset:LutOffset. Addition is modulo 2**PC_W; negative offsets wrap. InstrCount+=1.
  - Else: ProgCtr<=ProgCtr+1, wrapping 2**PC_W-1 -> 0. InstrCount+=1.
  - Ack has priority over BranchEn.
  - Offset 0 with BranchEn holds the PC (self-loop), still counting.
- DONE: hold ProgCtr and InstrCount, Done=1 until Start or Reset. Ack/BranchEn ignored.
- InstrCount saturates at 2**CNT_W-1 and does not wrap.
- OffsetSrc and both offsets are don't-care when BranchEn=0 or outside RUN.
- Latency: a PC update is visible on ProgCtr one cycle after the instruction is presented. Done rises the cycle after Ack is sampled in RUN.

Test Plan:
- Reset, then Start with StartAddr=0x000, no branches, Ack at PC=5 -> ProgCtr 0,1,2,3,4,5; Done=1 next cycle; InstrCount=6; ProgCtr holds 5.
- RUN at PC=0x010, BranchEn=1, OffsetSrc=0, LutOffset=0x3F6 (-10) -> ProgCtr=0x006. Then OffsetSrc=1, RegOffset=0x004 -> ProgCtr=0x00A; LutOffset ignored.
- PC=0x3FF, no branch -> ProgCtr=0x000. PC=0x002, branch with offset 0x3FC (-4) -> ProgCtr=0x3FE.
- Ack=1 and BranchEn=1 in the same cycle at PC=0x020 -> DONE, ProgCtr stays 0x020. Start+Ack in the same cycle with StartAddr=0x100 -> RUN at 0x100, InstrCount=0.
- Reset asserted mid-RUN at PC=0x055 -> next cycle ProgCtr=0, IDLE, Running=0, Done=0, InstrCount=0. Reset+Start together -> Reset wins.
- CNT_W=4, 20 sequential instructions with no Ack -> InstrCount saturates at 15. Start in DONE -> count clears to 0 and the PC reloads.
